// File: rtl/lis_membus_pkg.sv
// Shared types and helpers for the LIS CPU byte-bus memory responder.
package lis_membus_pkg;

    localparam int DEFAULT_WA = 30;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } membus_state_t;

    // Little-endian lane select: byte k of the word lives at bits [8k+7:8k].
    function automatic logic [3:0] lane_be(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/lis_word_buffer.sv
// One-word read buffer: tag/valid/data, hit compare, lane read mux,
// write-through byte merge, fill from external memory and invalidate.
module lis_word_buffer
    import lis_membus_pkg::*;
#(
    parameter int WA = DEFAULT_WA
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [WA-1:0] lookup_tag,
    input  logic [1:0]    lane,
    input  logic          merge_en,
    input  logic [7:0]    merge_byte,
    input  logic          fill_en,
    input  logic [WA-1:0] fill_tag,
    input  logic [31:0]   fill_data,
    input  logic          inv,
    output logic          hit,
    output logic [7:0]    rd_byte
);

    logic          valid;
    logic [WA-1:0] tag;
    logic [31:0]   data;
    logic [31:0]   merged_data;
    logic [3:0]    merge_mask;

    assign hit        = valid && (tag == lookup_tag);
    assign rd_byte    = hit ? data[{lane, 3'b000} +: 8] : 8'h00;
    assign merge_mask = lane_be(lane);

    always_comb begin
        merged_data = data;
        for (int k = 0; k < 4; k++) begin
            if (merge_mask[k]) begin
                merged_data[8*k +: 8] = merge_byte;
            end
        end
    end

    // A fill always loads data/tag; an invalidate on the same edge still wins
    // over valid so a racing fill is refetched rather than trusted.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else begin
            if (fill_en) begin
                data  <= fill_data;
                tag   <= fill_tag;
                valid <= 1'b1;
            end else if (merge_en && hit) begin
                data <= merged_data;
            end
            if (inv) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cpu_membus.sv
// CPU byte-bus responder in front of a 32-bit word memory, write-through/no-allocate.
// Define LIS_MEMBUS_WRITE_POST_EN to let writes retire before the external write completes.
module cpu_membus
    import lis_membus_pkg::*;
#(
    parameter int WA = DEFAULT_WA
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [31:0]   address,
    output logic [7:0]    in,
    input  logic [7:0]    out,
    input  logic          we,
    output logic          ce,
    input  logic          inv,
    output logic [WA-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ready
);

    membus_state_t state;
    logic [WA-1:0] word_addr;
    logic          hit;
    logic          merge_en;
    logic          fill_en;

    assign word_addr = address[WA+1:2];

    lis_word_buffer #(
        .WA(WA)
    ) u_buffer (
        .clock      (clock),
        .reset_n    (reset_n),
        .lookup_tag (word_addr),
        .lane       (address[1:0]),
        .merge_en   (merge_en),
        .merge_byte (out),
        .fill_en    (fill_en),
        .fill_tag   (mem_addr),
        .fill_data  (mem_rdata),
        .inv        (inv),
        .hit        (hit),
        .rd_byte    (in)
    );

    // The CPU clock enable is decided from the current state and the
    // address it is presenting this cycle.
    always_comb begin
        ce       = 1'b0;
        merge_en = 1'b0;
        fill_en  = 1'b0;
        case (state)
            IDLE: begin
                merge_en = we;
`ifdef LIS_MEMBUS_WRITE_POST_EN
                ce = we | hit;
`else
                ce = ~we & hit;
`endif
            end
            RD: begin
                fill_en = mem_ready;
            end
            WR: begin
`ifdef LIS_MEMBUS_WRITE_POST_EN
                ce = hit & ~we;
`else
                ce = 1'b0;
`endif
            end
            DONE: begin
                ce = 1'b1;
            end
            default: begin
                ce = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (we) begin
                        mem_addr  <= word_addr;
                        mem_be    <= lane_be(address[1:0]);
                        mem_wdata <= {4{out}};
                        mem_wr    <= 1'b1;
                        state     <= WR;
                    end else if (!hit) begin
                        mem_addr <= word_addr;
                        mem_rd   <= 1'b1;
                        state    <= RD;
                    end
                end
                RD: begin
                    if (mem_ready) begin
                        mem_rd <= 1'b0;
                        state  <= IDLE;
                    end
                end
                WR: begin
                    if (mem_ready) begin
                        mem_wr <= 1'b0;
`ifdef LIS_MEMBUS_WRITE_POST_EN
                        state  <= IDLE;
`else
                        state  <= DONE;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
